accumulator_stage: RTL and testbench

ACCUMULATOR_STAGE -- requirements
Module: accumulator_stage

---
 rtl/accumulator_stage.sv | 131 +++++++++++++
 tb/tb_accumulator_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/accumulator_stage.sv
// accumulator_stage: frame-based signed/unsigned accumulator with a
// valid/ready operand input and a valid/ready result output.
//
// Operands are added to or subtracted from a running accumulator, one beat
// per cycle. A beat flagged as last closes the frame. The closing result,
// the sticky carry/borrow and overflow flags, and the beat count are then
// held until downstream takes them. Taking the result clears the frame and
// re-opens the input on the same edge.
//
// Optional feature: define ACCUMULATOR_STAGE_SATURATE_EN to clamp the
// accumulator to the most positive or most negative value on a signed
// overflow. Without the macro, the accumulator wraps modulo 2^N.

module accumulator_stage #(
    parameter int N     = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_operand,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]       r_state;
    logic [N-1:0]     r_acc;
    logic             r_carry;
    logic             r_overflow;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_release;
    logic [N:0]       w_sum;
    logic [N:0]       w_diff;
    logic [N-1:0]     w_raw;
    logic             w_carry;
    logic             w_overflow;
    logic [N-1:0]     w_next_acc;
    logic             w_count_full;

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);

    assign w_accept     = in_valid && (r_state == ACCUM);
    assign w_release    = out_ready && (r_state == HOLD);
    assign w_count_full = &r_count;

    // Compute the beat's result, unsigned carry/borrow and signed overflow.
    // The top bit of the extended difference is set exactly when the
    // subtrahend exceeds the accumulator as an unsigned value.
    always_comb begin
        w_sum      = {1'b0, r_acc} + {1'b0, in_operand};
        w_diff     = {1'b0, r_acc} - {1'b0, in_operand};
        w_raw      = w_sum[N-1:0];
        w_carry    = w_sum[N];
        w_overflow = 1'b0;
        if (in_sub) begin
            w_raw      = w_diff[N-1:0];
            w_carry    = w_diff[N];
            w_overflow = (r_acc[N-1] != in_operand[N-1]) &&
                         (w_diff[N-1] != r_acc[N-1]);
        end else begin
            w_overflow = (r_acc[N-1] == in_operand[N-1]) &&
                         (w_sum[N-1] != r_acc[N-1]);
        end
    end

`ifdef ACCUMULATOR_STAGE_SATURATE_EN
    // Clamp on overflow. The true result always has the accumulator's sign
    // when overflow occurs, so that sign selects the clamp direction.
    always_comb begin
        w_next_acc = w_raw;
        if (w_overflow) begin
            if (r_acc[N-1]) begin
                w_next_acc = {1'b1, {(N-1){1'b0}}};
            end else begin
                w_next_acc = {1'b0, {(N-1){1'b1}}};
            end
        end
    end
`else
    // Let the accumulator wrap modulo 2^N.
    always_comb begin
        w_next_acc = w_raw;
    end
`endif

    // Run the frame state machine, the accumulator, the sticky flags and the beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ACCUM;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
        end else if (w_release) begin
            r_state    <= ACCUM;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
        end else if (w_accept) begin
            r_acc      <= w_next_acc;
            r_carry    <= r_carry | w_carry;
            r_overflow <= r_overflow | w_overflow;
            if (!w_count_full) begin
                r_count <= r_count + 1'b1;
            end
            if (in_last) begin
                r_state <= HOLD;
            end
        end
    end

    assign out_result   = r_acc;
    assign out_carry    = r_carry;
    assign out_overflow = r_overflow;
    assign out_count    = r_count;

endmodule

// File: tb/tb_accumulator_stage.sv
// Directed testbench for accumulator_stage with N=4 and CNT_W=4.
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge that follows each rising edge.
// When ACCUMULATOR_STAGE_SATURATE_EN is defined, the overflow expectations
// switch to the clamped values.

module tb_accumulator_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_operand;
    logic       in_sub;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_carry;
    logic       out_overflow;
    logic [3:0] out_count;

    int checks = 0;
    int errors = 0;

    accumulator_stage #(.N(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_operand   (in_operand),
        .in_sub       (in_sub),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_count    (out_count)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs at the falling edge and step to the next falling edge.
    task automatic applyStimulus(input logic valid, input logic [3:0] operand,
                                 input logic sub, input logic last, input logic ready);
        in_valid   = valid;
        in_operand = operand;
        in_sub     = sub;
        in_last    = last;
        out_ready  = ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check the full output state at once.
    task automatic checkAll(input string tag, input logic rdy, input logic vld,
                            input logic [3:0] res, input logic cy,
                            input logic ov, input logic [3:0] cnt);
        checkOutput({tag, ".in_ready"},     {31'd0, in_ready},     {31'd0, rdy});
        checkOutput({tag, ".out_valid"},    {31'd0, out_valid},    {31'd0, vld});
        checkOutput({tag, ".out_result"},   {28'd0, out_result},   {28'd0, res});
        checkOutput({tag, ".out_carry"},    {31'd0, out_carry},    {31'd0, cy});
        checkOutput({tag, ".out_overflow"}, {31'd0, out_overflow}, {31'd0, ov});
        checkOutput({tag, ".out_count"},    {28'd0, out_count},    {28'd0, cnt});
    endtask

    // Linear directed sequence.
    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_operand = 4'd0;
        in_sub     = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        checkAll("reset", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First acceptance on the first edge after reset release.
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        checkAll("t1.beat1", 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 4'd1);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
        checkAll("t1.hold", 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 4'd2);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checkAll("t1.release", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

        // Adding +5 and +4 produces a signed overflow.
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b1, 1'b0);
`ifdef ACCUMULATOR_STAGE_SATURATE_EN
        checkAll("t2.ovf", 1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 4'd2);
`else
        checkAll("t2.ovf", 1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 4'd2);
`endif
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Subtracting 3 from +2 borrows without a signed overflow.
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
        checkAll("t3.borrow", 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 4'd2);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Adding -8 and -8 sets carry and overflow.
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b1, 1'b0);
`ifdef ACCUMULATOR_STAGE_SATURATE_EN
        checkAll("t4.negovf", 1'b0, 1'b1, 4'b1000, 1'b1, 1'b1, 4'd2);
`else
        checkAll("t4.negovf", 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 4'd2);
`endif
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Stall in HOLD while in_valid stays high.
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
        checkAll("t5.hold", 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 4'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
            checkAll("t5.stall", 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 4'd1);
        end
        applyStimulus(1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
        checkAll("t5.release", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
        checkAll("t5.accept", 1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 4'd1);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Send 20 beats of +0, then a last beat; the counter saturates.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        checkAll("t6.sat", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd15);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Assert reset mid-frame; the outputs clear without a clock edge.
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkAll("t7.rstmid", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Assert reset in HOLD, then accept on the first edge after release.
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
        checkOutput("t8.inhold", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkAll("t8.rsthold", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        checkAll("t8.first", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
